// File: rtl/dmem_responder.sv
// Word-addressed data RAM with a req/ready/ack handshake and a fixed response latency.
// Define DMEM_BYTE_STROBE_EN to add the be_i byte-lane write strobes.
module dmem_responder #(
  parameter int DEPTH_WORDS = 32,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  be_i,
`endif
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            hold_we, hold_err;
  logic [AW-1:0]   hold_idx;
  logic [31:0]     hold_wdata;
  logic [3:0]      hold_be;
  logic [3:0]      be;
  logic [31:0]     mem [DEPTH_WORDS];
  logic            accept, legal;

`ifdef DMEM_BYTE_STROBE_EN
  assign be = be_i;
`else
  assign be = 4'hF;
`endif

  assign accept = req_i && ready_o;
  // Full-width bound check so out-of-range addresses never alias onto a valid word.
  assign legal  = (addr_i[1:0] == 2'b00) && (addr_i < 32'(DEPTH_WORDS * 4));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == CW'(1)) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state == IDLE);
    ack_o   = (state == RESP);
    err_o   = ack_o && hold_err;
    rdata_o = (ack_o && !hold_we && !hold_err) ? mem[hold_idx] : 32'd0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt        <= '0;
      hold_we    <= 1'b0;
      hold_err   <= 1'b0;
      hold_idx   <= '0;
      hold_wdata <= '0;
      hold_be    <= '0;
    end else begin
      if (state == IDLE && accept) begin
        cnt        <= CW'(LATENCY - 1);
        hold_we    <= we_i;
        hold_err   <= !legal;
        hold_idx   <= addr_i[AW+1:2];
        hold_wdata <= wdata_i;
        hold_be    <= be;
      end else if (state == WAIT) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Store commits on the edge that ends the RESP cycle, so the ack'd load data is pre-write.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (state == RESP && hold_we && !hold_err) begin
      for (int n = 0; n < 4; n++)
        if (hold_be[n]) mem[hold_idx][8*n +: 8] <= hold_wdata[8*n +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (DEPTH_WORDS=32, LATENCY=3).
module tb_dmem_responder;
  localparam int DEPTH = 32;
  localparam int LAT   = 3;

  logic        clk, rst, req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        ready, ack, err;
  logic [31:0] rdata;

  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  int          checks, failures;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .be_i(be),
`endif
    .ready_o(ready), .ack_o(ack), .rdata_o(rdata), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Wait for ready, issue one request, then track it to its ack and score it.
  task automatic txn(input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b);
    exp_t e, got;
    bit   seen;
    int   waited;
    waited = 0;
    while (!ready && waited < 20) begin @(negedge clk); waited++; end
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    e.we = w; e.addr = a; e.wdata = d;
`ifdef DMEM_BYTE_STROBE_EN
    e.be = b;
`else
    e.be = 4'hF;
`endif
    e.err   = !((a[1:0] == 2'b00) && (a < 32'(DEPTH * 4)));
    e.rdata = (!w && !e.err) ? model[a[6:2]] : 32'd0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req = 1'b0; addr = 32'h0000_0004; wdata = 32'hFFFF_FFFF; we = ~w;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (ack) begin
        seen = 1;
        got = sb.pop_front();
        chk({tag, "_latency"}, 32'(c), 32'(LAT - 1));
        chk({tag, "_err"}, 32'(err), 32'(got.err));
        chk({tag, "_rdata"}, rdata, got.rdata);
        if (got.we && !got.err)
          for (int n = 0; n < 4; n++)
            if (got.be[n]) model[got.addr[6:2]][8*n +: 8] = got.wdata[8*n +: 8];
      end else begin
        chk({tag, "_busy_ready"}, 32'(ready), 32'd0);
      end
    end
    if (!seen) begin
      chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    @(negedge clk);
    chk({tag, "_ack_pulse"}, {ack, err, ready}, 32'b001);
  endtask

  initial begin
    int acks;
    logic [31:0] busy_rdata;
    checks = 0; failures = 0;
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = 4'hF;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_outputs", {ready, ack, err}, 32'b100);
    chk("reset_rdata", rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    txn("st_beef", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    txn("ld_beef", 1'b0, 32'h10, 32'h0, 4'hF);
    txn("st_w0",   1'b1, 32'h00, 32'hCAFEF00D, 4'hF);
    txn("st_w31",  1'b1, 32'h7C, 32'h0BADC0DE, 4'hF);
    txn("ld_w31",  1'b0, 32'h7C, 32'h0, 4'hF);

    txn("ld_misal", 1'b0, 32'h12, 32'h0, 4'hF);
    txn("st_oor",   1'b1, 32'h80, 32'h55555555, 4'hF);
    txn("st_misal", 1'b1, 32'h02, 32'h66666666, 4'hF);
    txn("st_hi",    1'b1, 32'h8000_0000, 32'h77777777, 4'hF);
    txn("ld_w0",    1'b0, 32'h00, 32'h0, 4'hF);

    // req held high with a wandering address while busy: exactly one ack.
    acks = 0; busy_rdata = '0;
    req = 1'b1; we = 1'b0; addr = 32'h10;
    @(posedge clk);
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      addr = 32'(c * 4);
      if (ack) begin acks++; busy_rdata = rdata; req = 1'b0; end
    end
    req = 1'b0;
    chk("busy_single_ack", 32'(acks), 32'd1);
    chk("busy_rdata", busy_rdata, model[4]);

`ifdef DMEM_BYTE_STROBE_EN
    txn("be_full", 1'b1, 32'h08, 32'hAABBCCDD, 4'hF);
    txn("be_0101", 1'b1, 32'h08, 32'h11223344, 4'b0101);
    txn("be_ld",   1'b0, 32'h08, 32'h0, 4'hF);
    chk("be_model", model[2], 32'hAA22CC44);
    txn("be_none", 1'b1, 32'h08, 32'hFFFFFFFF, 4'b0000);
    txn("be_ld2",  1'b0, 32'h08, 32'h0, 4'hF);
`endif

    // Abort a store mid-wait; nothing may commit or ack.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h4; wdata = 32'h12345678;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("abort_outputs", {ready, ack, err}, 32'b100);
    chk("abort_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    acks = 0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    txn("abort_ld4", 1'b0, 32'h4, 32'h0, 4'hF);
    chk("abort_ld4_zero", model[1], 32'd0);
    txn("rst_ld10", 1'b0, 32'h10, 32'h0, 4'hF);
    txn("rst_ld0",  1'b0, 32'h0, 32'h0, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
